// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract. Operands are registered, then pass through
// three stages: align, add, normalise/round/pack. Fixed 3-cycle latency with a global clken stall.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clken,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   ope1,
    input  logic [EXP_W+MAN_W:0]   ope2,
    input  logic                   is_neg,
    input  logic                   is_sub,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    output logic [TAG_W-1:0]       out_tag,
    output logic [EXP_W+MAN_W:0]   q
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int XW  = MAN_W + 4;
    localparam int SW  = MAN_W + 5;
    localparam int EW2 = EXP_W + 2;
    localparam int LZW = $clog2(XW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] DIFF_MAX = EXP_W'(MAN_W + 3);

    function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = {LZW{1'b0}};
        found = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic                   s0_valid_q, s1_valid_q, s2_valid_q;
    logic [TAG_W-1:0]       s0_tag_q, s1_tag_q, s2_tag_q;
    logic [W-1:0]           s0_a_q, s0_b_q;
    logic                   s1_sign_q, s1_sub_q, s1_spec_q, s2_sign_q, s2_spec_q;
    logic [EXP_W-1:0]       s1_exp_q, s1_diff_q, s2_exp_q;
    logic [MAN_W:0]         s1_mana_q, s1_manb_q;
    logic [W-1:0]           s1_spec_val_q, s2_spec_val_q;
    logic [SW-1:0]          s2_sum_q;

    // stage 1: flush, classify, order operands by magnitude
    logic                   sa_d, sb_d, za_d, zb_d, ia_d, ib_d, swap_d, spec_d;
    logic [W-2:0]           fa_d, fb_d, big_d, small_d;
    logic [EXP_W-1:0]       diff_raw_d, diff_d;
    logic [W-1:0]           spec_val_d;

    always_comb begin
        sa_d       = s0_a_q[W-1];
        sb_d       = s0_b_q[W-1];
        za_d       = (s0_a_q[W-2:MAN_W] == {EXP_W{1'b0}});
        zb_d       = (s0_b_q[W-2:MAN_W] == {EXP_W{1'b0}});
        ia_d       = (s0_a_q[W-2:MAN_W] == EXP_ONES);
        ib_d       = (s0_b_q[W-2:MAN_W] == EXP_ONES);
        fa_d       = za_d ? {(W-1){1'b0}} : s0_a_q[W-2:0];
        fb_d       = zb_d ? {(W-1){1'b0}} : s0_b_q[W-2:0];
        swap_d     = (fb_d > fa_d);
        big_d      = swap_d ? fb_d : fa_d;
        small_d    = swap_d ? fa_d : fb_d;
        diff_raw_d = big_d[W-2:MAN_W] - small_d[W-2:MAN_W];
        diff_d     = (diff_raw_d > DIFF_MAX) ? DIFF_MAX : diff_raw_d;
        spec_d     = 1'b1;
        if (ia_d && ib_d) begin
            spec_val_d = (sa_d == sb_d) ? {sa_d, EXP_ONES, {MAN_W{1'b0}}}
                                        : {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (ia_d) begin
            spec_val_d = {sa_d, EXP_ONES, {MAN_W{1'b0}}};
        end else if (ib_d) begin
            spec_val_d = {sb_d, EXP_ONES, {MAN_W{1'b0}}};
        end else if (za_d && zb_d) begin
            spec_val_d = {sa_d & sb_d, {(W-1){1'b0}}};
        end else begin
            spec_d     = 1'b0;
            spec_val_d = {W{1'b0}};
        end
    end

    // stage 2: align the smaller mantissa with guard/round/sticky, then add or subtract
    logic [2*XW-1:0]        shw_d;
    logic [XW-1:0]          ma_ext_d, mb_ext_d;
    logic [SW-1:0]          sum_d;

    always_comb begin
        shw_d    = {s1_manb_q, 3'b000, {XW{1'b0}}} >> s1_diff_q;
        mb_ext_d = {shw_d[2*XW-1:XW+1], shw_d[XW] | (|shw_d[XW-1:0])};
        ma_ext_d = {s1_mana_q, 3'b000};
        if (s1_sub_q) begin
            sum_d = {1'b0, ma_ext_d} - {1'b0, mb_ext_d};
        end else begin
            sum_d = {1'b0, ma_ext_d} + {1'b0, mb_ext_d};
        end
    end

    // stage 3: normalise, round to nearest even, resolve overflow/underflow and pack
    logic [LZW-1:0]         lz_d;
    logic [XW-1:0]          norm_d;
    logic [EW2-1:0]         exp_n_d, exp_r_d;
    logic                   rnd_up_d;
    logic [MAN_W+1:0]       man_r_d;
    logic [MAN_W-1:0]       frac_d;
    logic [W-1:0]           q_d;

    always_comb begin
        lz_d = lzc(s2_sum_q[XW-1:0]);
        if (s2_sum_q[SW-1]) begin
            norm_d  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n_d = {2'b00, s2_exp_q} + EW2'(1);
        end else begin
            norm_d  = s2_sum_q[XW-1:0] << lz_d;
            exp_n_d = {2'b00, s2_exp_q} - EW2'(lz_d);
        end
        rnd_up_d = norm_d[2] & (norm_d[1] | norm_d[0] | norm_d[3]);
        man_r_d  = {1'b0, norm_d[XW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up_d};
        exp_r_d  = man_r_d[MAN_W+1] ? (exp_n_d + EW2'(1)) : exp_n_d;
        frac_d   = man_r_d[MAN_W+1] ? man_r_d[MAN_W:1] : man_r_d[MAN_W-1:0];
        if (s2_spec_q) begin
            q_d = s2_spec_val_q;
        end else if (s2_sum_q == {SW{1'b0}}) begin
            q_d = {W{1'b0}};
        end else if (exp_n_d[EW2-1] || (exp_n_d == {EW2{1'b0}})) begin
            q_d = {s2_sign_q, {(W-1){1'b0}}};
        end else if (exp_r_d >= {2'b00, EXP_ONES}) begin
            q_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            q_d = {s2_sign_q, exp_r_d[EXP_W-1:0], frac_d};
        end
    end

    // pipeline registers; clken low freezes every rank including valid bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_valid_q <= 1'b0; s0_tag_q <= {TAG_W{1'b0}};
            s0_a_q <= {W{1'b0}}; s0_b_q <= {W{1'b0}};
            s1_valid_q <= 1'b0; s1_tag_q <= {TAG_W{1'b0}};
            s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_spec_q <= 1'b0;
            s1_exp_q <= {EXP_W{1'b0}}; s1_diff_q <= {EXP_W{1'b0}};
            s1_mana_q <= {(MAN_W+1){1'b0}}; s1_manb_q <= {(MAN_W+1){1'b0}};
            s1_spec_val_q <= {W{1'b0}};
            s2_valid_q <= 1'b0; s2_tag_q <= {TAG_W{1'b0}};
            s2_sign_q <= 1'b0; s2_spec_q <= 1'b0; s2_exp_q <= {EXP_W{1'b0}};
            s2_sum_q <= {SW{1'b0}}; s2_spec_val_q <= {W{1'b0}};
            out_valid <= 1'b0; out_tag <= {TAG_W{1'b0}}; q <= {W{1'b0}};
        end else if (clken) begin
            s0_valid_q    <= in_valid;
            s0_tag_q      <= in_tag;
            s0_a_q        <= {ope1[W-1] ^ is_neg, ope1[W-2:0]};
            s0_b_q        <= {ope2[W-1] ^ is_sub, ope2[W-2:0]};
            s1_valid_q    <= s0_valid_q;
            s1_tag_q      <= s0_tag_q;
            s1_sign_q     <= swap_d ? sb_d : sa_d;
            s1_sub_q      <= sa_d ^ sb_d;
            s1_spec_q     <= spec_d;
            s1_spec_val_q <= spec_val_d;
            s1_exp_q      <= big_d[W-2:MAN_W];
            s1_diff_q     <= diff_d;
            s1_mana_q     <= {|big_d[W-2:MAN_W], big_d[MAN_W-1:0]};
            s1_manb_q     <= {|small_d[W-2:MAN_W], small_d[MAN_W-1:0]};
            s2_valid_q    <= s1_valid_q;
            s2_tag_q      <= s1_tag_q;
            s2_sign_q     <= s1_sign_q;
            s2_spec_q     <= s1_spec_q;
            s2_spec_val_q <= s1_spec_val_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= sum_d;
            out_valid     <= s2_valid_q;
            out_tag       <= s2_tag_q;
            q             <= q_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: expected results queue on issue and are checked
// (value, tag, enabled-cycle latency) when out_valid appears.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rstn, clken, in_valid, is_neg, is_sub;
    logic [31:0] ope1, ope2, q;
    logic [4:0]  in_tag, out_tag;
    logic        out_valid;

    typedef struct {
        logic [31:0] q;
        logic [4:0]  tag;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    bit   sb_on  = 1'b1;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk(clk), .rstn(rstn), .clken(clken), .in_valid(in_valid),
        .ope1(ope1), .ope2(ope2), .is_neg(is_neg), .is_sub(is_sub),
        .in_tag(in_tag), .out_valid(out_valid), .out_tag(out_tag), .q(q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, got, expv);
        end
    endtask

    task automatic step(input logic en, input logic vld, input logic [31:0] a, input logic [31:0] b,
                        input logic neg, input logic sub, input logic [4:0] tag, input logic [31:0] eq);
        logic [31:0] pq;
        logic        pv;
        logic [4:0]  pt;
        exp_t        e;
        clken = en; in_valid = vld; ope1 = a; ope2 = b;
        is_neg = neg; is_sub = sub; in_tag = tag;
        pq = q; pv = out_valid; pt = out_tag;
        @(posedge clk);
        if (en) begin
            en_cnt++;
            if (vld && sb_on) sb.push_back('{eq, tag, en_cnt + 3});
        end
        @(negedge clk);
        if (!en) begin
            chk("hold_q", q, pq);
            chk("hold_valid", {31'b0, out_valid}, {31'b0, pv});
            chk("hold_tag", {27'b0, out_tag}, {27'b0, pt});
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("q_tag%0d", e.tag), q, e.q);
                chk($sformatf("tag_tag%0d", e.tag), {27'b0, out_tag}, {27'b0, e.tag});
                chk($sformatf("latency_tag%0d", e.tag), 32'(en_cnt), 32'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due == en_cnt) begin
            chk($sformatf("missing_tag%0d", sb[0].tag), {31'b0, out_valid}, 32'd1);
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic neg, input logic sub,
                      input logic [4:0] tag, input logic [31:0] eq);
        step(1'b1, 1'b1, a, b, neg, sub, tag, eq);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic stall();
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 5'd31, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) idle();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; clken = 1'b0; in_valid = 1'b0; is_neg = 1'b0; is_sub = 1'b0;
        ope1 = 32'h0; ope2 = 32'h0; in_tag = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_q", q, 32'h0);
        chk("rst_tag", {27'b0, out_tag}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        op(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 5'd1, 32'h40400000);
        drain();

        op(32'h3F800000, 32'h40000000, 1'b1, 1'b0, 5'd2,  32'h3F800000);
        op(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 5'd3,  32'hBF800000);
        op(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 5'd4,  32'h00000000);
        op(32'h3F800000, 32'h33800000, 1'b0, 1'b0, 5'd5,  32'h3F800000);
        op(32'h3F800001, 32'h33800000, 1'b0, 1'b0, 5'd6,  32'h3F800002);
        op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 5'd7,  32'h7F800000);
        op(32'h00000001, 32'h3F800000, 1'b0, 1'b0, 5'd8,  32'h3F800000);
        op(32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 5'd9,  32'h7FC00000);
        op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 5'd10, 32'h80000000);
        op(32'h40400000, 32'h40000000, 1'b0, 1'b1, 5'd20, 32'h3F800000);
        op(32'h3F800000, 32'hBF7FFFFF, 1'b0, 1'b0, 5'd21, 32'h33800000);
        op(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 1'b0, 5'd22, 32'hFF800000);
        op(32'hFF800000, 32'h3F800000, 1'b0, 1'b0, 5'd23, 32'hFF800000);
        op(32'h80800001, 32'h00800000, 1'b0, 1'b0, 5'd24, 32'h80000000);
        drain();

        op(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 5'd11, 32'h40400000);
        op(32'h40000000, 32'h40000000, 1'b0, 1'b0, 5'd12, 32'h40800000);
        op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 5'd13, 32'h40000000);
        op(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 5'd14, 32'h40000000);
        stall();
        stall();
        drain();

        op(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 5'd15, 32'h40400000);
        sb_on = 1'b0;
        op(32'h40000000, 32'h40000000, 1'b0, 1'b0, 5'd25, 32'h0);
        op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 5'd26, 32'h0);
        op(32'h40400000, 32'h3F800000, 1'b0, 1'b0, 5'd27, 32'h0);
        sb_on = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_q", q, 32'h0);
        chk("async_rst_tag", {27'b0, out_tag}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) idle();
        op(32'h40000000, 32'h3F800000, 1'b0, 1'b0, 5'd16, 32'h40400000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined floating-point add/subtract unit for the FPU datapath.
- Operand sign controls (is_neg on operand 1, is_sub on operand 2) let one instance serve add, sub, negated add and the add stage of fmad.
- Fixed 3-cycle latency, one issue per enabled cycle, valid/tag sideband for out-of-order writeback matching, global clken stall.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width (hidden bit implicit).
- TAG_W, 5, width of sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- clken  in  1  pipeline advance enable; low freezes every stage.
- in_valid  in  1  operation present on inputs this cycle.
- ope1  in  1+EXP_W+MAN_W  operand 1 {sign, exp, man}.
- ope2  in  1+EXP_W+MAN_W  operand 2.
- is_neg  in  1  invert sign of ope1 before add.
- is_sub  in  1  invert sign of ope2 before add.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  q/out_tag hold a completed result.
- out_tag  out  TAG_W  tag of the completed operation.
- q  out  1+EXP_W+MAN_W  result.

Behaviour:
- Reset (rstn low, any time, asynchronous): all stage valid bits, out_valid, out_tag, q cleared to 0. In-flight operations are discarded; nothing emerges after release.
- Operation: a = ope1 with sign^is_neg; b = ope2 with sign^is_sub; q = a + b.
- Timing: sampled at edge N with clken=1 and in_valid=1 -> out_valid=1 after edge N+3, provided clken=1 at N+1..N+3.
- clken=0: no register changes, including valid bits. Outputs hold. Inputs are ignored that cycle.
- in_valid=0 with clken=1 inserts a bubble. Data registers may change freely. out_valid=0 for that slot.
- Stage 1: unpack; flush exp==0 operands to signed zero (no denormal support); detect inf (exp all ones, any mantissa treated as inf); swap so |A|>=|B| by {exp,man}; effective-subtract flag = signA^signB; exponent difference saturates at MAN_W+3.
- Stage 2: right-shift B mantissa (hidden bit restored) by the difference, keeping guard, round and sticky (OR of all shifted-out bits); add or subtract magnitudes in MAN_W+5 bits.
- Stage 3:
  - Normalise: leading-zero count left shift, or 1-bit right shift on carry-out with sticky update.
  - Round to nearest, ties to even. Handle rounding carry into exponent.
  - Pack the result.
- Special results:
  - Exact zero result is +0, except (-0)+(-0) = -0.
  - Result exponent >= all-ones -> signed inf {s, all ones, 0}.
  - Result exponent <= 0 after normalise -> signed zero (flush).
  - inf + finite -> that inf.
  - inf + same-sign inf -> that inf.
  - inf + opposite inf -> canonical NaN {0, all ones, 1 followed by zeros}.
- No exception flags. Output is deterministic for every input pattern.

Test Plan:
- 0x3F800000 + 0x40000000, is_neg=0, is_sub=0 -> q=0x40400000, out_valid exactly 3 enabled cycles later, out_tag equals in_tag.
- ope1=0x3F800000 with is_neg=1, ope2=0x40000000 -> 0x3F800000. Same operands, is_sub=1, is_neg=0 -> 0xBF800000. 0x3F800000 minus itself via is_sub -> 0x00000000.
- Rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even). 0x3F800001 + 0x33800000 -> 0x3F800002.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x00000001 + 0x3F800000 -> 0x3F800000 (denormal flushed).
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Back-to-back issue of 4 ops with distinct tags, clken dropped 2 cycles mid-stream -> results in order, tags intact, each output held during stall, no duplicates or losses.
- rstn pulsed low while 3 ops are in flight -> out_valid=0 and q=0 immediately. No stale result appears after rstn returns high; a new op issued afterwards completes normally.
